video_frame_reader: RTL and testbench

Display-side reader for the frame buffer, and the source of the 24-bit RGB pixel stream and `in_frame` flag that the video filter consumes. It follows the XVGA raster (`hcount`/`vcount`/syncs/blank) and issues one memory read per two in-frame pixels. It unpacks 6:6:6 pixel pairs into 8:8:8 RGB and delays the sync signals so the pixels and timing leave aligned. It also supports double buffering with a buffer swap taken only at frame start.

---
 rtl/video_frame_reader_if.sv | 28 ++
 rtl/video_frame_reader.sv | 156 +++++++++++++++
 tb/tb_video_frame_reader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/video_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_reader_if
//  Description : Frame-buffer read bus between the display-side reader
//                (master) and the memory (slave).
//                  mem_addr : word address, registered by the reader
//                  mem_re   : one-cycle read strobe
//                  mem_data : read data, returned a fixed latency later
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_frame_reader_if;
    logic [18:0] mem_addr;
    logic        mem_re;
    logic [35:0] mem_data;

    modport master (
        output mem_addr,
        output mem_re,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        output mem_data
    );
endinterface
`default_nettype wire

// File: rtl/video_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_reader
//  Description : Display-side frame-buffer reader. Follows the raster,
//                issues one read per two in-frame pixels, unpacks 6:6:6
//                pixel pairs into 8:8:8 RGB and delays the raster timing so
//                pixels and syncs leave aligned. The display buffer is
//                swapped only at frame start (hcount == vcount == 0).
//  Ports       : clk, reset_n (sync, active low)
//                hcount/vcount/hsync/vsync/blank : input raster timing
//                buffer_sel                      : requested display buffer
//                mem (master)                    : frame-buffer read bus
//                rgb_out/in_frame                : pixel stream
//                hsync_out/vsync_out/blank_out   : timing delayed to match
//  Revision    : 1.0 - initial release
// ============================================================================
module video_frame_reader #(
    parameter int unsigned FRAME_X   = 64,
    parameter int unsigned FRAME_Y   = 48,
    parameter int unsigned FRAME_W   = 512,
    parameter int unsigned FRAME_H   = 384,
    parameter logic [18:0] BUF1_BASE = 19'h20000,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [10:0]                 hcount,
    input  logic [9:0]                  vcount,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic                        blank,
    input  logic                        buffer_sel,
    video_frame_reader_if.master        mem,
    output logic [23:0]                 rgb_out,
    output logic                        in_frame,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        blank_out
);
    // Input sample -> read issue (1) -> memory (MEM_LAT) -> pixel register (1)
    localparam int          LAT  = int'(MEM_LAT) + 2;
    localparam logic [10:0] X_LO = 11'(FRAME_X);
    localparam logic [10:0] X_HI = 11'(FRAME_X + FRAME_W);
    localparam logic [9:0]  Y_LO = 10'(FRAME_Y);
    localparam logic [9:0]  Y_HI = 10'(FRAME_Y + FRAME_H);

    // Bit positions inside one delay-line entry
    localparam int          C_WIN     = 4;
    localparam int          C_ODD     = 3;
    localparam int          C_HS      = 2;
    localparam int          C_VS      = 1;
    localparam int          C_BL      = 0;
    localparam logic [4:0]  CTRL_IDLE = 5'b00111;

    function automatic logic [23:0] unpack666(input logic [17:0] px);
        return {px[17:12], px[17:16], px[11:6], px[11:10], px[5:0], px[5:4]};
    endfunction

    logic [4:0]  ctrl_q [LAT];
    logic        cur_buf_q,  cur_buf_d;
    logic        armed_q,    armed_d;
    logic [18:0] addr_cnt_q, addr_cnt_d;
    logic [18:0] mem_addr_q, mem_addr_d;
    logic        mem_re_q,   mem_re_d;
    logic [17:0] odd_px_q,   odd_px_d;
    logic [23:0] rgb_q,      rgb_d;
    logic        in_frame_q, hsync_q, vsync_q, blank_q;

    logic        frame_start;
    logic        win;
    logic        parity;
    logic        rd_req;
    logic [4:0]  out_ctrl;

    always_comb begin
        frame_start = (hcount == 11'd0) && (vcount == 10'd0);
        // After reset nothing is shown until a frame start has re-armed the
        // reader, so a partial frame never reads from a stale address.
        win         = (hcount >= X_LO) && (hcount < X_HI) &&
                      (vcount >= Y_LO) && (vcount < Y_HI) && !blank &&
                      (armed_q || frame_start);
        parity      = hcount[0] ^ X_LO[0];
        armed_d     = armed_q | frame_start;
        cur_buf_d   = frame_start ? buffer_sel : cur_buf_q;

        // Reads are issued from the first delay stage, one clock after the
        // even-pixel input, so a frame-start base load (on the input cycle)
        // always lands before the first read of that frame.
        rd_req      = ctrl_q[0][C_WIN] & ~ctrl_q[0][C_ODD];
        mem_re_d    = rd_req;
        mem_addr_d  = rd_req ? addr_cnt_q : mem_addr_q;
        if (frame_start) begin
            addr_cnt_d = cur_buf_d ? BUF1_BASE : 19'd0;
        end else if (rd_req) begin
            addr_cnt_d = addr_cnt_q + 19'd1;
        end else begin
            addr_cnt_d = addr_cnt_q;
        end

        // The even half is consumed on the edge the word returns; only the
        // odd half needs holding for the following pixel.
        out_ctrl = ctrl_q[LAT-1];
        odd_px_d = (out_ctrl[C_WIN] && !out_ctrl[C_ODD]) ? mem.mem_data[17:0] : odd_px_q;
        if (!out_ctrl[C_WIN]) begin
            rgb_d = 24'h000000;
        end else if (out_ctrl[C_ODD]) begin
            rgb_d = unpack666(odd_px_q);
        end else begin
            rgb_d = unpack666(mem.mem_data[35:18]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_buf_q  <= 1'b0;
            armed_q    <= 1'b0;
            addr_cnt_q <= 19'd0;
            mem_addr_q <= 19'd0;
            mem_re_q   <= 1'b0;
            odd_px_q   <= 18'd0;
            rgb_q      <= 24'h000000;
            in_frame_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b1;
            for (int i = 0; i < LAT; i++) begin
                ctrl_q[i] <= CTRL_IDLE;
            end
        end else begin
            cur_buf_q  <= cur_buf_d;
            armed_q    <= armed_d;
            addr_cnt_q <= addr_cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_re_q   <= mem_re_d;
            odd_px_q   <= odd_px_d;
            rgb_q      <= rgb_d;
            in_frame_q <= out_ctrl[C_WIN];
            hsync_q    <= out_ctrl[C_HS];
            vsync_q    <= out_ctrl[C_VS];
            blank_q    <= out_ctrl[C_BL];
            ctrl_q[0]  <= {win, parity, hsync, vsync, blank};
            for (int i = 1; i < LAT; i++) begin
                ctrl_q[i] <= ctrl_q[i-1];
            end
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_re   = mem_re_q;
    assign rgb_out      = rgb_q;
    assign in_frame     = in_frame_q;
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign blank_out    = blank_q;
endmodule
`default_nettype wire

// File: tb/tb_video_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_frame_reader
//  Description : Self-checking bench for video_frame_reader on a reduced
//                raster (24x12 total, 8x4 window at (4,2)).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_frame_reader;
    localparam int          FX = 4, FY = 2, FW = 8, FH = 4, ML = 2, L = ML + 2;
    localparam int          HT = 24, VT = 12, N = 4096;
    localparam logic [18:0] B1 = 19'h20000;

    logic        clk = 1'b0;
    logic        reset_n, hsync, vsync, blank, buffer_sel;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] rgb_out;
    logic        in_frame, hsync_out, vsync_out, blank_out;
    int          hx, vy;

    video_frame_reader_if mbus();

    video_frame_reader #(
        .FRAME_X(FX), .FRAME_Y(FY), .FRAME_W(FW), .FRAME_H(FH),
        .BUF1_BASE(B1), .MEM_LAT(ML)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .buffer_sel(buffer_sel),
        .mem(mbus), .rgb_out(rgb_out), .in_frame(in_frame),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    // Frame-buffer contents; two words pinned for hand-computed checks.
    function automatic logic [35:0] memfn(input logic [18:0] a);
        if (a == 19'h00000) return {18'h3F000, 18'h00FC0};
        if (a == 19'h20000) return {18'h0003F, 18'h3FFFF};
        return {a[17:0] ^ 18'h15A5A, a[17:0] * 18'd37 + 18'd11};
    endfunction

    function automatic logic [23:0] expand(input logic [17:0] p);
        return {p[17:12], p[17:16], p[11:6], p[11:10], p[5:0], p[5:4]};
    endfunction

    // Memory with MEM_LAT=2 register stages; garbage when not read.
    logic [35:0] m1 = 36'h0;
    always @(posedge clk) begin
        m1            <= mbus.mem_re ? memfn(mbus.mem_addr) : 36'hA5A5A5A5A;
        mbus.mem_data <= m1;
    end

    // Record the inputs seen at every active edge.
    int          cyc = 0;
    logic [10:0] h_s  [N];
    logic [9:0]  v_s  [N];
    logic        hs_s [N], vs_s [N], bl_s [N], rs_s [N], bs_s [N];
    always @(posedge clk) begin
        h_s[cyc % N]  <= hcount;
        v_s[cyc % N]  <= vcount;
        hs_s[cyc % N] <= hsync;
        vs_s[cyc % N] <= vsync;
        bl_s[cyc % N] <= blank;
        rs_s[cyc % N] <= !reset_n;
        bs_s[cyc % N] <= buffer_sel;
        cyc           <= cyc + 1;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", nm, cyc - 1, got, want);
        end
    endtask

    // Behavioural model: per sampled raster position, what it must produce.
    logic        act [N];
    logic        odd [N];
    logic        cbm [N];
    logic [18:0] adr [N];

    initial begin : model
        logic        fv, cb, clean, rst, exp_re;
        int          e, ei, s, hh, vv, p, lrst, rd_cnt;
        logic [35:0] w;
        logic [23:0] px;
        fv = 1'b0; cb = 1'b0; clean = 1'b0; lrst = 0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            e  = cyc - 1;
            ei = e % N;
            hh = int'(h_s[ei]);
            vv = int'(v_s[ei]);
            rst = rs_s[ei];
            if (rst) begin
                fv = 1'b0; cb = 1'b0; clean = 1'b0; lrst = e;
            end else if (hh == 0 && vv == 0) begin
                if (clean) chk("reads_per_frame", 64'(rd_cnt), 64'd16);
                rd_cnt = 0; clean = 1'b1; fv = 1'b1; cb = bs_s[ei];
            end
            act[ei] = !rst && fv && !bl_s[ei] && hh >= FX && hh < FX + FW &&
                      vv >= FY && vv < FY + FH;
            p       = (vv - FY) * FW + (hh - FX);
            odd[ei] = p[0];
            cbm[ei] = cb;
            adr[ei] = (cb ? B1 : 19'h0) + 19'(p / 2);
            if (mbus.mem_re) rd_cnt++;

            if (rst)
                chk("reset_state",
                    64'({rgb_out, in_frame, mbus.mem_re, mbus.mem_addr, hsync_out, vsync_out, blank_out}),
                    64'({24'h0, 1'b0, 1'b0, 19'h0, 3'b111}));

            if (e >= 1) begin
                s = (e - 1) % N;
                exp_re = act[s] && !odd[s] && !rst;
                chk("mem_re", 64'(mbus.mem_re), 64'(exp_re));
                if (exp_re) begin
                    chk("mem_addr", 64'(mbus.mem_addr), 64'(adr[s]));
                    if (int'(h_s[s]) == FX && int'(v_s[s]) == FY)
                        chk("first_addr", 64'(mbus.mem_addr), cbm[s] ? 64'h20000 : 64'h0);
                    if (int'(h_s[s]) == FX && int'(v_s[s]) == FY + FH - 1)
                        chk("last_line_addr", 64'(mbus.mem_addr), cbm[s] ? 64'h2000C : 64'hC);
                end
            end

            if (e < L || lrst >= e - L) begin
                chk("pixel", 64'({in_frame, rgb_out}), 64'h0);
                chk("timing", 64'({hsync_out, vsync_out, blank_out}), 64'h7);
            end else begin
                s  = (e - L) % N;
                w  = memfn(adr[s]);
                px = act[s] ? expand(odd[s] ? w[17:0] : w[35:18]) : 24'h0;
                chk("pixel", 64'({in_frame, rgb_out}), 64'({act[s], px}));
                chk("timing", 64'({hsync_out, vsync_out, blank_out}),
                    64'({hs_s[s], vs_s[s], bl_s[s]}));
                if (act[s] && int'(h_s[s]) == FX && int'(v_s[s]) == FY)
                    chk("first_even_px", 64'(rgb_out), cbm[s] ? 64'h0000FF : 64'hFF0000);
                if (act[s] && int'(h_s[s]) == FX + 1 && int'(v_s[s]) == FY)
                    chk("first_odd_px", 64'(rgb_out), cbm[s] ? 64'hFFFFFF : 64'h00FF00);
            end
        end
    end

    // Raster driver: hsync low at h 21..22, vsync low on line 11,
    // blank outside 20x10.
    task automatic apply();
        hcount = 11'(hx);
        vcount = 10'(vy);
        hsync  = !(hx == 21 || hx == 22);
        vsync  = !(vy == 11);
        blank  = (hx >= 20) || (vy >= 10);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (hx == HT - 1) begin
            hx = 0;
            vy = (vy == VT - 1) ? 0 : vy + 1;
        end else begin
            hx = hx + 1;
        end
        apply();
    endtask

    task automatic run_until(input int th, input int tv);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(hx == th && vy == tv) && n < 2000);
        if (!(hx == th && vy == tv)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_until(%0d,%0d): cycle budget expired", th, tv);
        end
    endtask

    initial begin : stim
        reset_n = 1'b0; buffer_sel = 1'b0; hx = 0; vy = 3;
        apply();
        repeat (5) tick();
        reset_n = 1'b1;
        run_until(0, 0);                      // frame A, buffer 0
        run_until(0, 4);
        buffer_sel = 1'b1;                    // mid-frame request
        run_until(0, 0);                      // frame B, buffer 1
        run_until(6, 4);
        reset_n = 1'b0;                       // one-clock reset inside the window
        tick();
        reset_n = 1'b1;
        buffer_sel = 1'b0;
        run_until(0, 0);                      // frame C, buffer 0
        run_until(20, 11);
        buffer_sel = 1'b1;
        reset_n = 1'b0;
        repeat (4) tick();
        reset_n = 1'b1;                       // release on the frame-start edge
        run_until(0, 0);                      // frame D, buffer 1
        run_until(0, 3);
        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
